// File: rtl/clock_stopwatch_core.sv
// Time-of-day clock with field-wise set mode plus an independent stopwatch (start/stop, lap, clear).
// Optional alarm comparator is compiled in when ALARM_EN is defined.
module clock_stopwatch_core #(
  parameter int DIV      = 500000,
  parameter int HOUR_MOD = 24,
  parameter int INIT_H   = 23,
  parameter int INIT_M   = 59,
  parameter int INIT_S   = 50
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       MODE,
  input  logic [1:0] FLAG,
  input  logic       UP,
  input  logic       DWN,
  input  logic       SS,
  input  logic       LAP,
  input  logic       CLR,
`ifdef ALARM_EN
  input  logic [7:0] ALM_H,
  input  logic [7:0] ALM_M,
  input  logic       ALM_ON,
  output logic       ALARM,
`endif
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic [7:0] Centi_second,
  output logic       RUNNING,
  output logic       DAY_WRAP
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = (HOUR_MOD > 1) ? $clog2(HOUR_MOD) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [HW-1:0] HMAX = HW'(HOUR_MOD - 1);
  localparam logic [HW-1:0] HONE = HW'(1);

  typedef enum logic [1:0] {SW_STOP, SW_RUN, SW_LAP} sw_state_t;

  logic [4:0] btn_q, btn_ev;
  logic       up_ev, dn_ev, ss_ev, lap_ev, clr_ev;
  assign btn_ev = {UP, DWN, SS, LAP, CLR} & ~btn_q;
  assign {up_ev, dn_ev, ss_ev, lap_ev, clr_ev} = btn_ev;

  logic [PW-1:0] c_pre;
  logic          tick_c, roll, wrap_q;
  logic [HW-1:0] c_h, n_h;
  logic [5:0]    c_m, n_m, c_s, n_s;
  logic [6:0]    c_cs, n_cs;

  assign tick_c = (FLAG == 2'b00) && (c_pre == PMAX);

  always_comb begin
    n_h  = c_h;
    n_m  = c_m;
    n_s  = c_s;
    n_cs = c_cs;
    roll = 1'b0;
    if (FLAG == 2'b00) begin
      if (tick_c) begin
        if (c_cs != 7'd99) n_cs = c_cs + 7'd1;
        else begin
          n_cs = '0;
          if (c_s != 6'd59) n_s = c_s + 6'd1;
          else begin
            n_s = '0;
            if (c_m != 6'd59) n_m = c_m + 6'd1;
            else begin
              n_m = '0;
              if (c_h != HMAX) n_h = c_h + HONE;
              else begin
                n_h  = '0;
                roll = 1'b1;
              end
            end
          end
        end
      end
    end else begin
      // simultaneous UP and DWN cancel; each field wraps on its own, no carry
      if (up_ev != dn_ev) begin
        case (FLAG)
          2'b01:   n_h = up_ev ? ((c_h == HMAX) ? '0 : c_h + HONE)
                               : ((c_h == '0) ? HMAX : c_h - HONE);
          2'b10:   n_m = up_ev ? ((c_m == 6'd59) ? '0 : c_m + 6'd1)
                               : ((c_m == '0) ? 6'd59 : c_m - 6'd1);
          default: n_s = up_ev ? ((c_s == 6'd59) ? '0 : c_s + 6'd1)
                               : ((c_s == '0) ? 6'd59 : c_s - 6'd1);
        endcase
      end
      if (FLAG == 2'b11 && (up_ev || dn_ev)) n_cs = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      btn_q  <= '0;
      c_pre  <= '0;
      c_h    <= HW'(INIT_H);
      c_m    <= 6'(INIT_M);
      c_s    <= 6'(INIT_S);
      c_cs   <= '0;
      wrap_q <= 1'b0;
    end else begin
      btn_q  <= {UP, DWN, SS, LAP, CLR};
      c_pre  <= (FLAG != 2'b00 || c_pre == PMAX) ? '0 : c_pre + PONE;
      c_h    <= n_h;
      c_m    <= n_m;
      c_s    <= n_s;
      c_cs   <= n_cs;
      wrap_q <= roll;
    end
  end

  sw_state_t     sw_st, sw_nxt;
  logic          sw_go, sw_latch, hold_on, hold_off, sw_zero, hold, running, tick_s;
  logic [PW-1:0] sw_pre;
  logic [6:0]    sw_cs, sw_h, lp_cs, lp_h;
  logic [5:0]    sw_s, sw_m, lp_s, lp_m;

  assign running = (sw_st != SW_STOP);
  assign tick_s  = running && (sw_pre == PMAX);
  assign RUNNING = running;

  always_comb begin
    sw_nxt   = sw_st;
    sw_go    = 1'b0;
    sw_latch = 1'b0;
    hold_on  = 1'b0;
    hold_off = 1'b0;
    sw_zero  = 1'b0;
    case (sw_st)
      SW_STOP: begin
        if (ss_ev) begin
          sw_nxt = SW_RUN;
          sw_go  = 1'b1;
        end else begin
          sw_zero  = clr_ev;
          hold_off = clr_ev || lap_ev;
        end
      end
      SW_RUN: begin
        if (ss_ev) sw_nxt = SW_STOP;
        else if (lap_ev) begin
          sw_nxt   = SW_LAP;
          sw_latch = 1'b1;
          hold_on  = 1'b1;
        end
      end
      SW_LAP: begin
        if (ss_ev) sw_nxt = SW_STOP;
        else if (lap_ev) begin
          sw_nxt   = SW_RUN;
          hold_off = 1'b1;
        end
      end
      default: sw_nxt = SW_STOP;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) sw_st <= SW_STOP;
    else        sw_st <= sw_nxt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sw_pre <= '0;
      hold   <= 1'b0;
      {sw_h, sw_m, sw_s, sw_cs} <= '0;
      {lp_h, lp_m, lp_s, lp_cs} <= '0;
    end else begin
      if (sw_go || !running || sw_pre == PMAX) sw_pre <= '0;
      else                                      sw_pre <= sw_pre + PONE;
      if (hold_off)     hold <= 1'b0;
      else if (hold_on) hold <= 1'b1;
      if (sw_zero) begin
        {sw_h, sw_m, sw_s, sw_cs} <= '0;
        {lp_h, lp_m, lp_s, lp_cs} <= '0;
      end else begin
        if (sw_latch) {lp_h, lp_m, lp_s, lp_cs} <= {sw_h, sw_m, sw_s, sw_cs};
        if (tick_s) begin
          if (sw_cs != 7'd99) sw_cs <= sw_cs + 7'd1;
          else begin
            sw_cs <= '0;
            if (sw_s != 6'd59) sw_s <= sw_s + 6'd1;
            else begin
              sw_s <= '0;
              if (sw_m != 6'd59) sw_m <= sw_m + 6'd1;
              else begin
                sw_m <= '0;
                sw_h <= (sw_h == 7'd99) ? '0 : sw_h + 7'd1;
              end
            end
          end
        end
      end
    end
  end

  // wrap_q is one cycle behind the counter, so DAY_WRAP lines up with the displayed 00:00:00.00
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Hour         <= 8'(INIT_H);
      Minute       <= 8'(INIT_M);
      Second       <= 8'(INIT_S);
      Centi_second <= '0;
      DAY_WRAP     <= 1'b0;
    end else begin
      DAY_WRAP <= wrap_q;
      if (!MODE) begin
        Hour <= 8'(c_h);  Minute <= 8'(c_m);  Second <= 8'(c_s);  Centi_second <= 8'(c_cs);
      end else if (hold) begin
        Hour <= 8'(lp_h); Minute <= 8'(lp_m); Second <= 8'(lp_s); Centi_second <= 8'(lp_cs);
      end else begin
        Hour <= 8'(sw_h); Minute <= 8'(sw_m); Second <= 8'(sw_s); Centi_second <= 8'(sw_cs);
      end
    end
  end

`ifdef ALARM_EN
  logic alm_hit_q, alm_min_q, alm_ud_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      alm_hit_q <= 1'b0;
      alm_min_q <= 1'b0;
      alm_ud_q  <= 1'b0;
      ALARM     <= 1'b0;
    end else begin
      alm_hit_q <= tick_c && ALM_ON && (8'(n_h) == ALM_H) && (8'(n_m) == ALM_M)
                   && (n_s == '0) && (n_cs == '0);
      alm_min_q <= (n_m != c_m);
      alm_ud_q  <= up_ev || dn_ev;
      if (!ALM_ON || alm_ud_q) ALARM <= 1'b0;
      else if (alm_hit_q)      ALARM <= 1'b1;
      else if (alm_min_q)      ALARM <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_clock_stopwatch_core.sv
// Self-checking bench for clock_stopwatch_core: directed steps plus random stimulus against a
// centisecond-count reference model of the clock and stopwatch.
module tb_clock_stopwatch_core;
  localparam int DIV      = 2;
  localparam int HOUR_MOD = 24;
  localparam int INIT_H   = 23;
  localparam int INIT_M   = 59;
  localparam int INIT_S   = 50;
  localparam int DAYCS    = HOUR_MOD * 360000;
  localparam int SWCS     = 100 * 360000;

  logic       CLK = 1'b0, RESET = 1'b1, MODE = 1'b0;
  logic [1:0] FLAG = 2'b00;
  logic       UP = 1'b0, DWN = 1'b0, SS = 1'b0, LAP = 1'b0, CLR = 1'b0;
  logic [7:0] Hour, Minute, Second, Centi_second;
  logic       RUNNING, DAY_WRAP;
`ifdef ALARM_EN
  logic [7:0] ALM_H = 8'd0, ALM_M = 8'd0;
  logic       ALM_ON = 1'b0;
  logic       ALARM;
`endif

  int checks = 0, failures = 0;
  int tod, cpre, sw, spre, lapv, dw_seen, live;
  logic m_run, m_lapmode, m_hold, wrap_pend;
  logic p_up, p_dn, p_ss, p_lap, p_clr;
  logic [31:0] d_disp;
  logic        d_dw;
  string phase;

  always #5 CLK = ~CLK;

  clock_stopwatch_core #(
    .DIV(DIV), .HOUR_MOD(HOUR_MOD), .INIT_H(INIT_H), .INIT_M(INIT_M), .INIT_S(INIT_S)
  ) dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .FLAG(FLAG),
    .UP(UP), .DWN(DWN), .SS(SS), .LAP(LAP), .CLR(CLR),
`ifdef ALARM_EN
    .ALM_H(ALM_H), .ALM_M(ALM_M), .ALM_ON(ALM_ON), .ALARM(ALARM),
`endif
    .Hour(Hour), .Minute(Minute), .Second(Second), .Centi_second(Centi_second),
    .RUNNING(RUNNING), .DAY_WRAP(DAY_WRAP)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] split(input int v);
    return {8'(v / 360000), 8'((v / 6000) % 60), 8'((v / 100) % 60), 8'(v % 100)};
  endfunction

  task automatic model_reset();
    tod = INIT_H * 360000 + INIT_M * 6000 + INIT_S * 100;
    cpre = 0; sw = 0; spre = 0; lapv = 0;
    m_run = 0; m_lapmode = 0; m_hold = 0; wrap_pend = 0;
    {p_up, p_dn, p_ss, p_lap, p_clr} = '0;
    d_disp = split(tod);
    d_dw = 0;
  endtask

  task automatic model_edge();
    logic e_up, e_dn, e_ss, e_lap, e_clr;
    int h, m, s, c, old_sw;
    e_up = UP & ~p_up; e_dn = DWN & ~p_dn; e_ss = SS & ~p_ss;
    e_lap = LAP & ~p_lap; e_clr = CLR & ~p_clr;
    {p_up, p_dn, p_ss, p_lap, p_clr} = {UP, DWN, SS, LAP, CLR};
    d_disp = !MODE ? split(tod) : (m_hold ? split(lapv) : split(sw));
    d_dw = wrap_pend;
    wrap_pend = 0;
    if (FLAG == 2'b00) begin
      if (cpre == DIV - 1) begin
        cpre = 0;
        tod = (tod + 1) % DAYCS;
        wrap_pend = (tod == 0);
      end else cpre++;
    end else begin
      cpre = 0;
      h = tod / 360000; m = (tod / 6000) % 60; s = (tod / 100) % 60; c = tod % 100;
      if (e_up != e_dn) begin
        if (FLAG == 2'b01) h = e_up ? (h + 1) % HOUR_MOD : (h + HOUR_MOD - 1) % HOUR_MOD;
        if (FLAG == 2'b10) m = e_up ? (m + 1) % 60 : (m + 59) % 60;
        if (FLAG == 2'b11) s = e_up ? (s + 1) % 60 : (s + 59) % 60;
      end
      if (FLAG == 2'b11 && (e_up || e_dn)) c = 0;
      tod = h * 360000 + m * 6000 + s * 100 + c;
    end
    old_sw = sw;
    if (m_run) begin
      if (spre == DIV - 1) begin
        spre = 0;
        sw = (sw + 1) % SWCS;
      end else spre++;
    end
    if (!m_run) begin
      if (e_ss) begin
        m_run = 1; spre = 0;
      end else begin
        if (e_clr) begin sw = 0; lapv = 0; m_hold = 0; end
        if (e_lap) m_hold = 0;
      end
    end else if (e_ss) begin
      m_run = 0; m_lapmode = 0;
    end else if (e_lap) begin
      if (!m_lapmode) begin m_lapmode = 1; lapv = old_sw; m_hold = 1; end
      else begin m_lapmode = 0; m_hold = 0; end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check(phase, {Hour, Minute, Second, Centi_second, RUNNING, DAY_WRAP}, {d_disp, m_run, d_dw});
      if (DAY_WRAP) dw_seen++;
    end
  endtask

  initial begin
    model_reset();
    phase = "reset";
    #2 RESET = 1'b0;
    #1 check("reset_async", {Hour, Minute, Second, Centi_second, RUNNING, DAY_WRAP},
             {8'd23, 8'd59, 8'd50, 8'd0, 2'b00});
    @(negedge CLK);
    RESET = 1'b1;

    phase = "run_to_wrap"; dw_seen = 0;
    cyc(2100);
    check("day_wrap_pulses", dw_seen, 1);
    check("after_wrap_hms", {Hour, Minute, Second}, 24'h0);

    phase = "hour_set";
    FLAG = 2'b01; cyc(2);
    DWN = 1; cyc(10); DWN = 0; cyc(2);
    check("hour_dwn_wrap", Hour, 8'd23);
    UP = 1; cyc(10); UP = 0; cyc(2);
    check("hour_up_wrap", Hour, 8'd0);
    UP = 1; DWN = 1; cyc(3); UP = 0; DWN = 0; cyc(2);
    check("hour_updn_same", Hour, 8'd0);
    phase = "sec_set";
    FLAG = 2'b11; cyc(1);
    UP = 1; cyc(3); UP = 0; cyc(1);
    check("sec_set", {Second, Centi_second}, {8'd1, 8'd0});

    phase = "sw_start";
    FLAG = 2'b00; MODE = 1; cyc(2);
    SS = 1; cyc(1); SS = 0; cyc(200);
    live = Second * 100 + Centi_second;
    check("sw_1s_window", (live >= 99 && live <= 101), 1);
    check("sw_running", RUNNING, 1);
    phase = "sw_lap";
    LAP = 1; cyc(1); LAP = 0; cyc(60);
    check("lap_running", RUNNING, 1);
    LAP = 1; cyc(1); LAP = 0; cyc(5);
    live = Second * 100 + Centi_second;
    check("lap_live_larger", live > lapv, 1);

    phase = "sw_stop_clear";
    SS = 1; cyc(1); SS = 0; cyc(5);
    check("sw_stopped", RUNNING, 0);
    CLR = 1; cyc(1); CLR = 0; cyc(2);
    check("sw_cleared", {Hour, Minute, Second, Centi_second}, 32'h0);
    SS = 1; cyc(1); SS = 0; cyc(20);
    CLR = 1; cyc(1); CLR = 0; cyc(2);
    check("clr_ignored_running", Centi_second != 8'd0, 1);
    SS = 1; cyc(1); SS = 0; cyc(2);
    SS = 1; CLR = 1; cyc(1); SS = 0; CLR = 0; cyc(4);
    check("ss_clr_runs", RUNNING, 1);
    check("ss_clr_not_cleared", Centi_second != 8'd0, 1);

    phase = "independence";
    FLAG = 2'b10;
    for (int i = 0; i < 60; i++) begin
      MODE = 1'($urandom_range(0, 1));
      cyc(1);
    end

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      MODE = 1'($urandom_range(0, 1));
      FLAG = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      UP   = ($urandom_range(0, 3) == 0);
      DWN  = ($urandom_range(0, 3) == 0);
      SS   = ($urandom_range(0, 5) == 0);
      LAP  = ($urandom_range(0, 5) == 0);
      CLR  = ($urandom_range(0, 5) == 0);
      cyc(1);
    end

    phase = "reset_mid_run";
    {UP, DWN, SS, LAP, CLR} = '0;
    FLAG = 2'b00; MODE = 1;
    #2 RESET = 1'b0;
    #1 check("reset_async_run", {Hour, Minute, Second, Centi_second, RUNNING, DAY_WRAP},
             {8'd23, 8'd59, 8'd50, 8'd0, 2'b00});
    model_reset();
    @(negedge CLK);
    RESET = 1'b1; MODE = 0;
    phase = "post_reset";
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
